// File: rtl/flags_reporter.sv
// Reader for the matmul over/underflow flags register: snapshots the flag
// vector once per pass and streams each set flag out as a (row, col, index) event.
module flags_reporter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int IDX_WIDTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         clr_req_i,
  input  logic                         flags_we_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   flags_i,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [IDX_WIDTH-1:0]         evt_row_o,
  output logic [IDX_WIDTH-1:0]         evt_col_o,
  output logic [CNT_WIDTH-1:0]         evt_index_o,
  output logic [CNT_WIDTH-1:0]         count_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         clear_o
);
  localparam int F = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_OUT, S_DONE} state_t;

  state_t               state, state_d;
  logic [F-1:0]         snap;
  logic [F-1:0]         snap_sh;
  logic [CNT_WIDTH-1:0] k;
  logic                 clr_lat;
  logic                 cur_bit;
  logic                 last;

  // Shift rather than index so k may be wider than log2(F).
  assign snap_sh = snap >> k;
  assign cur_bit = snap_sh[0];
  assign last    = (k == CNT_WIDTH'(F - 1));

  assign evt_valid_o = (state == S_OUT);
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign clear_o     = (state == S_DONE) && clr_lat;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start_i) state_d = flags_we_i ? S_WAIT : S_SCAN;
      S_WAIT: if (!flags_we_i) state_d = S_SCAN;
      S_SCAN: begin
        if (cur_bit)   state_d = S_OUT;
        else if (last) state_d = S_DONE;
      end
      S_OUT:  if (evt_ready_i) state_d = last ? S_DONE : S_SCAN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      snap        <= '0;
      k           <= '0;
      clr_lat     <= 1'b0;
      count_o     <= '0;
      evt_row_o   <= '0;
      evt_col_o   <= '0;
      evt_index_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          clr_lat <= clr_req_i;
          count_o <= '0;
          k       <= '0;
          if (!flags_we_i) snap <= flags_i;
        end
        // The flags register floats while being written, so wait it out.
        S_WAIT: if (!flags_we_i) begin
          snap <= flags_i;
          k    <= '0;
        end
        S_SCAN: begin
          if (cur_bit) begin
            evt_row_o   <= IDX_WIDTH'(k / CNT_WIDTH'(MAX_DIM));
            evt_col_o   <= IDX_WIDTH'(k % CNT_WIDTH'(MAX_DIM));
            evt_index_o <= k;
          end else if (!last) begin
            k <= k + 1'b1;
          end
        end
        S_OUT: if (evt_ready_i) begin
          count_o     <= count_o + 1'b1;
          evt_row_o   <= '0;
          evt_col_o   <= '0;
          evt_index_o <= '0;
          if (!last) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flags_reporter.sv
// Randomized bench for flags_reporter: expected events and pass summaries are
// queued by the stimulus and checked by an independent monitor.
module tb_flags_reporter;
  localparam int DW = 32, BW = 64, MD = BW / DW, F = MD * MD, IW = 4, CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, clr_req, we, ready;
  logic [F-1:0]  flags;
  logic          evt_valid, busy, done, clear;
  logic [IW-1:0] row, col;
  logic [CW-1:0] idx, cnt;

  int n_chk = 0, n_fail = 0;
  int evq[$];
  int dq_cnt[$];
  bit dq_clr[$];
  int ready_mode = 0;  // 0 always, 1 random, 2 stall 3 cycles per event, 3 never
  int sc = 0;

  flags_reporter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clr_req_i(clr_req),
    .flags_we_i(we), .flags_i(flags), .evt_valid_o(evt_valid), .evt_ready_i(ready),
    .evt_row_o(row), .evt_col_o(col), .evt_index_o(idx), .count_o(cnt),
    .busy_o(busy), .done_o(done), .clear_o(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: ready = 1'b1;
      1: ready = 1'($urandom_range(0, 1));
      2: begin
        if (!evt_valid) begin ready = 1'b0; sc = 0; end
        else if (sc < 3) begin ready = 1'b0; sc++; end
        else ready = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Monitor: every visible event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid) begin
        chk("evt_pending", int'(evq.size() > 0), 1);
        if (evq.size() > 0) begin
          chk("evt_index", int'(idx), evq[0]);
          chk("evt_row",   int'(row), evq[0] / MD);
          chk("evt_col",   int'(col), evq[0] % MD);
          if (ready) void'(evq.pop_front());
        end
      end
      if (done) begin
        chk("done_pending", int'(dq_cnt.size() > 0), 1);
        if (dq_cnt.size() > 0) begin
          chk("done_count", int'(cnt), dq_cnt.pop_front());
          chk("done_clear", int'(clear), int'(dq_clr.pop_front()));
        end
      end else if (clear) begin
        chk("clear_without_done", int'(clear), 0);
      end
    end
  end

  task automatic run_pass(input logic [F-1:0] val, input int we_cyc, input bit clr,
                          input int rmode, input bit hold);
    int e;
    bit seen;
    int pop;
    pop = $countones(val);
    ready_mode = rmode;
    for (int i = 0; i < F; i++) if (val[i]) evq.push_back(i);
    dq_cnt.push_back(pop);
    dq_clr.push_back(clr);
    start = 1'b1;
    clr_req = clr;
    if (we_cyc > 0) begin we = 1'b1; flags = F'($urandom); end
    else begin we = 1'b0; flags = val; end
    e = -1;
    seen = 1'b0;
    for (int g = 0; g < 200 && !seen; g++) begin
      @(posedge clk);
      e++;
      #1;
      if (!hold) start = 1'b0;
      clr_req = 1'($urandom_range(0, 1));
      if (e < we_cyc - 1) flags = F'($urandom);  // garbage while the register floats
      else if (e == we_cyc - 1) begin we = 1'b0; flags = val; end
      else begin flags = F'($urandom); we = 1'($urandom_range(0, 1)); end
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        we = 1'b0;
        if (rmode == 0) chk("pass_len", e, we_cyc + F + pop);
      end
    end
    chk("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    chk("count_after", int'(cnt), pop);
    @(posedge clk); #1;
    chk("count_hold", int'(cnt), pop);
    chk("evq_drained", evq.size(), 0);
    chk("no_restart", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr_req = 1'b0; we = 1'b0; flags = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'({evt_valid, row, col, idx, cnt, busy, done, clear}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass(4'b1010, 0, 1'b0, 0, 1'b0);
    run_pass(4'b0000, 0, 1'b1, 0, 1'b0);
    run_pass(4'b1111, 0, 1'b0, 2, 1'b0);
    run_pass(4'b0100, 5, 1'b1, 0, 1'b0);
    run_pass(4'b0110, 0, 1'b0, 1, 1'b1);

    // Reset while an event is pending.
    ready_mode = 3;
    evq.push_back(0);
    start = 1'b1; flags = 4'b0001; we = 1'b0; clr_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_valid", int'(evt_valid), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_pass_reset", int'({evt_valid, row, col, idx, cnt, busy, done, clear}), 0);
    evq.delete(); dq_cnt.delete(); dq_clr.delete();
    rst_n = 1'b1;
    run_pass(4'b0001, 0, 1'b0, 0, 1'b0);

    for (int t = 0; t < 24; t++)
      run_pass(F'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flags_reporter.md
Name: flags_reporter

Overview:
- Reader side of the matmul over/underflow flags register: snapshots the MAX_DIM^2 flag vector and reports each set flag as a (row, col, index) event over a valid/ready stream.
- Sits between the flags register and the APB/status logic, which drains events to build an error report.
- Samples only while the matmul is not writing flags, because the flags register drives Z during writes.
- Optionally requests a flags clear once reporting is complete.

Parameters:
- DATA_WIDTH, 32, matrix element width
- BUS_WIDTH, 64, system bus width
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, matrix dimension; number of flags F = MAX_DIM*MAX_DIM
- IDX_WIDTH, 4, width of row/col outputs; must satisfy 2^IDX_WIDTH >= MAX_DIM
- CNT_WIDTH, 8, width of index and count outputs; must satisfy 2^CNT_WIDTH > F

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  request a report pass; sampled high on a rising edge
- clr_req_i  in  1  sampled with start_i; 1 = pulse clear_o at end of pass
- flags_we_i  in  1  matmul flag write enable; flags_i invalid while high
- flags_i  in  F  flag vector; bit k = row*MAX_DIM + col
- evt_valid_o  out  1  event available
- evt_ready_i  in  1  consumer accepts event
- evt_row_o  out  IDX_WIDTH  row of flagged element (k / MAX_DIM)
- evt_col_o  out  IDX_WIDTH  col of flagged element (k % MAX_DIM)
- evt_index_o  out  CNT_WIDTH  flat index k
- count_o  out  CNT_WIDTH  events accepted in current/last pass
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at end of pass
- clear_o  out  1  one-cycle pulse with done_o if clr_req latched

Behaviour:
- Reset (rst_ni low at a rising edge) applies regardless of state, including mid-pass:
  - all outputs 0
  - snapshot, k and latched clr_req cleared
  - state IDLE
- States: IDLE, WAIT, SCAN, OUT, DONE.
- IDLE:
  - start_i high, flags_we_i low: snapshot <= flags_i, clr latched, count_o <= 0, k <= 0, go to SCAN.
  - start_i high, flags_we_i high: latch clr, count_o <= 0, go to WAIT.
- WAIT: first edge with flags_we_i low performs the snapshot, sets k <= 0 and goes to SCAN. start_i is ignored here.
- SCAN examines one bit per cycle:
  - snap[k] = 1: load evt_row/col/index from k, go to OUT. evt_valid_o is visible the cycle after that edge.
  - snap[k] = 0 and k = F-1: go to DONE.
  - otherwise: k <= k+1.
- OUT:
  - evt_valid_o is high. evt_row_o, evt_col_o and evt_index_o are held stable while evt_ready_i is low.
  - On the handshake edge (valid & ready): count_o <= count_o+1; go to DONE if k = F-1, else k <= k+1 and go to SCAN.
  - evt_valid_o must not depend combinationally on evt_ready_i.
- DONE:
  - done_o = 1 for exactly one cycle; clear_o = latched clr.
  - Next edge goes to IDLE.
  - Event outputs return to 0 when leaving OUT.
- start_i while busy_o is high is ignored; no queuing.
- Flag changes after the snapshot do not affect the pass in progress.
- count_o holds its value after DONE until the next accepted start.
- Pass length:
  - all-zero snapshot: start edge + F SCAN cycles + 1 DONE cycle.
  - each set flag adds at least 1 OUT cycle.
- Row/col computed by division/modulo by MAX_DIM; for power-of-two MAX_DIM these are bit slices.

Test Plan:
- MAX_DIM=2, flags_i=4'b1010, ready tied 1, start at edge 0:
  - valid after edge 2 with idx1/r0/c1, accepted at edge 3
  - valid after edge 5 with idx3/r1/c1, accepted at edge 6
  - done_o high the cycle after edge 6; count_o=2
- flags_i=4'b0000, start at edge 0:
  - evt_valid_o never high
  - done_o high after edge 4, exactly 1 cycle; count_o=0
- flags_i=4'b1111 with evt_ready_i low for 3 cycles on each event:
  - outputs stable during stall
  - events emitted in order 0,1,2,3
  - count_o=4
- flags_we_i high for 5 cycles when start_i asserts with flags_i Z:
  - state WAIT
  - snapshot taken on first edge with we low (value 4'b0100)
  - single event idx2/r1/c0
- clr_req_i=1 with start: clear_o pulses together with done_o. clr_req_i=0: clear_o stays 0.
- rst_ni low during OUT (flags 4'b0001):
  - next cycle all outputs 0, busy_o 0
  - new start produces a fresh pass with count_o restarting from 0
- start_i held high during a pass: no restart; exactly one done_o per accepted start.
